usart_packet_manager: RTL and testbench

Parametrised packet layer between the byte-level UART transceiver and the register/control logic of the Sigma Delta DAQ. It reassembles incoming bytes into fixed-length messages and splits them into command, register address and data fields. It queues outgoing messages in a TX FIFO and serialises them into bytes MSB-first. Compared with the previous packet manager, it adds:
- configurable message, field and queue sizes;
- an inter-byte timeout that resynchronises the receiver;
- overflow reporting.

---
 rtl/usart_packet_manager_if.sv | 39 +++
 rtl/usart_packet_manager.sv | 168 ++++++++++++++++
 tb/tb_usart_packet_manager.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usart_packet_manager_if.sv
// Handshake/data bundle between the packet manager and its UART and register-side neighbours.
// Latency: none (wires only).
// Backpressure: only the TX byte stream has a ready; the RX byte stream is strobe-only.
interface usart_packet_manager_if #(
  parameter int MSG_LENGTH    = 48,
  parameter int DATA_LENGTH   = 32,
  parameter int ADDRWIDTH     = 8,
  parameter int COMMAND_WIDTH = 5
);
  logic                     rx_byte_valid;
  logic [7:0]               rx_byte;
  logic                     tx_byte_valid;
  logic                     tx_byte_ready;
  logic [7:0]               tx_byte;
  logic                     send_data;
  logic [MSG_LENGTH-1:0]    tx_data;
  logic                     data_sent;
  logic                     tx_full;
  logic                     tx_overflow;
  logic                     packet_received;
  logic [COMMAND_WIDTH-1:0] command;
  logic [ADDRWIDTH-1:0]     reg_addr;
  logic [DATA_LENGTH-1:0]   rx_data;
  logic                     rx_timeout;

  // Packet manager side
  modport slave (
    input  rx_byte_valid, rx_byte, tx_byte_ready, send_data, tx_data,
    output tx_byte_valid, tx_byte, data_sent, tx_full, tx_overflow,
           packet_received, command, reg_addr, rx_data, rx_timeout
  );

  // UART / register-logic side
  modport master (
    output rx_byte_valid, rx_byte, tx_byte_ready, send_data, tx_data,
    input  tx_byte_valid, tx_byte, data_sent, tx_full, tx_overflow,
           packet_received, command, reg_addr, rx_data, rx_timeout
  );
endinterface

// File: rtl/usart_packet_manager.sv
// Reassembles UART bytes into fixed-length messages and serialises queued messages back to bytes, MSB first.
// Latency: decoded fields 1 cycle after the final RX byte; first TX byte 2 cycles after send_data when idle.
// Backpressure: tx_byte held while !tx_byte_ready; RX cannot stall (timeout resyncs); send_data on a full queue is dropped with tx_overflow.
module usart_packet_manager #(
  parameter int MSG_LENGTH     = 48,
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRWIDTH      = 8,
  parameter int COMMAND_WIDTH  = 5,
  parameter int TX_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                   clk,
  input logic                   reset_n,
  usart_packet_manager_if.slave bus
);
  localparam int MSG_BYTES = MSG_LENGTH / 8;
  localparam int BW        = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW        = $clog2(TX_DEPTH);
  localparam int CW        = $clog2(TX_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  // ---------------- RX path ----------------
  logic [MSG_LENGTH-1:0]    r_rx_shift;
  logic [MSG_LENGTH-1:0]    w_rx_next;
  logic [BW-1:0]            r_rx_cnt;
  logic [TW-1:0]            r_to_cnt;
  logic                     w_rx_last;
  logic                     w_timeout;
  logic                     r_pkt;
  logic [COMMAND_WIDTH-1:0] r_cmd;
  logic [ADDRWIDTH-1:0]     r_addr;
  logic [DATA_LENGTH-1:0]   r_data;

  assign w_rx_next = {r_rx_shift[MSG_LENGTH-9:0], bus.rx_byte};
  assign w_rx_last = (r_rx_cnt == BW'(MSG_BYTES - 1));
  // A strobe in the expiry cycle takes precedence, so the timeout is gated by it.
  assign w_timeout = (r_rx_cnt != '0) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) && !bus.rx_byte_valid;

  // Byte assembly, field decode on the final byte, and inter-byte timeout supervision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_to_cnt   <= '0;
      r_pkt      <= 1'b0;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_pkt <= 1'b0;
      if (bus.rx_byte_valid) begin
        r_rx_shift <= w_rx_next;
        r_to_cnt   <= '0;
        if (w_rx_last) begin
          r_rx_cnt <= '0;
          r_pkt    <= 1'b1;
          r_data   <= w_rx_next[DATA_LENGTH-1:0];
          r_addr   <= w_rx_next[DATA_LENGTH +: ADDRWIDTH];
          r_cmd    <= w_rx_next[DATA_LENGTH+ADDRWIDTH +: COMMAND_WIDTH];
        end else begin
          r_rx_cnt <= r_rx_cnt + BW'(1);
        end
      end else if (w_timeout) begin
        r_rx_cnt <= '0;
        r_to_cnt <= '0;
      end else if (r_rx_cnt != '0) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  // ---------------- TX queue ----------------
  logic [MSG_LENGTH-1:0] r_mem [TX_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_more;

  state_t                r_state;
  logic [MSG_LENGTH-1:0] r_tx_shift;
  logic [BW-1:0]         r_tx_idx;
  logic                  r_tx_vld;
  logic                  r_sent;
  logic                  w_hs;

  assign w_full = (r_count == CW'(TX_DEPTH));
  assign w_push = bus.send_data && !w_full;
  assign w_pop  = (r_state == S_LOAD);
  // Queue will hold at least one message after this cycle's write.
  assign w_more = (r_count != '0) || w_push;
  assign w_hs   = r_tx_vld && bus.tx_byte_ready;

  // Queue storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.tx_data;
  end

  // Queue pointers and occupancy count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Serialiser: pop a message in LOAD, then shift out one byte per handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_vld   <= 1'b0;
      r_sent     <= 1'b0;
    end else begin
      r_sent <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_more) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_tx_shift <= r_mem[r_rd_ptr];
          r_tx_idx   <= '0;
          r_tx_vld   <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            r_tx_shift <= r_tx_shift << 8;
            if (r_tx_idx == BW'(MSG_BYTES - 1)) begin
              r_tx_idx <= '0;
              r_tx_vld <= 1'b0;
              r_sent   <= 1'b1;
              r_state  <= w_more ? S_LOAD : S_IDLE;
            end else begin
              r_tx_idx <= r_tx_idx + BW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_byte_valid   = r_tx_vld;
  assign bus.tx_byte         = r_tx_shift[MSG_LENGTH-1 -: 8];
  assign bus.data_sent       = r_sent;
  assign bus.tx_full         = w_full;
  assign bus.tx_overflow     = bus.send_data && w_full;
  assign bus.packet_received = r_pkt;
  assign bus.command         = r_cmd;
  assign bus.reg_addr        = r_addr;
  assign bus.rx_data         = r_data;
  assign bus.rx_timeout      = w_timeout;
endmodule

// File: tb/tb_usart_packet_manager.sv
// Bench for usart_packet_manager: vector table, hand-written corner sequences, randomized run vs. queue model.
// Latency: n/a.
// Backpressure: bench drives tx_byte_ready directly.
module tb_usart_packet_manager;
  localparam int T = 10;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  usart_packet_manager_if #(.MSG_LENGTH(48), .DATA_LENGTH(32), .ADDRWIDTH(8), .COMMAND_WIDTH(5)) bus ();

  usart_packet_manager #(
    .MSG_LENGTH(48), .DATA_LENGTH(32), .ADDRWIDTH(8), .COMMAND_WIDTH(5),
    .TX_DEPTH(D), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [47:0] msg;
    logic [4:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
  } rx_vec_t;

  rx_vec_t     vecs[4];
  logic [7:0]  got_q[$];
  int          got_ds;
  logic [47:0] tx_msgs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rx_byte_valid = 1'b0;
    bus.rx_byte       = 8'h00;
    bus.tx_byte_ready = 1'b0;
    bus.send_data     = 1'b0;
    bus.tx_data       = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_vld"},  64'(bus.tx_byte_valid), 0);
    chk({tag, "_tx_byte"}, 64'(bus.tx_byte), 0);
    chk({tag, "_ds"},      64'(bus.data_sent), 0);
    chk({tag, "_full"},    64'(bus.tx_full), 0);
    chk({tag, "_ovf"},     64'(bus.tx_overflow), 0);
    chk({tag, "_pkt"},     64'(bus.packet_received), 0);
    chk({tag, "_cmd"},     64'(bus.command), 0);
    chk({tag, "_addr"},    64'(bus.reg_addr), 0);
    chk({tag, "_data"},    64'(bus.rx_data), 0);
    chk({tag, "_tout"},    64'(bus.rx_timeout), 0);
  endtask

  // Six strobes on consecutive cycles; leaves the bench at the start of the cycle after the last byte.
  task automatic send_rx_msg(input logic [47:0] m);
    for (int b = 0; b < 6; b++) begin
      bus.rx_byte_valid = 1'b1;
      bus.rx_byte       = m[47-8*b -: 8];
      @(negedge clk);
      chk("rx_no_early_pkt", 64'(bus.packet_received), 0);
      next_cycle();
    end
    bus.rx_byte_valid = 1'b0;
  endtask

  task automatic check_fields(input string tag, input logic [4:0] c, input logic [7:0] a, input logic [31:0] d);
    chk({tag, "_cmd"},  64'(bus.command), 64'(c));
    chk({tag, "_addr"}, 64'(bus.reg_addr), 64'(a));
    chk({tag, "_data"}, 64'(bus.rx_data), 64'(d));
  endtask

  task automatic collect_tx(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.data_sent) begin
        got_ds++;
        chk("ds_on_msg_boundary", 64'((got_q.size() % 6 == 0) && (got_q.size() > 0)), 1);
      end
      if (bus.tx_byte_valid && bus.tx_byte_ready) got_q.push_back(bus.tx_byte);
      next_cycle();
    end
  endtask

  task automatic run_random(input int ncyc, input logic [4:0] cmd0, input logic [7:0] addr0, input logic [31:0] data0);
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [47:0] msg_q[$];
    logic [4:0]  m_cmd;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic        m_pkt, m_ds, m_load;
    int          last_strobe, gap;
    logic        rv, sd, rdy, e_full, e_tout;
    logic [7:0]  rb;
    logic [47:0] td, m;
    m_cmd = cmd0; m_addr = addr0; m_data = data0;
    m_pkt = 1'b0; m_ds = 1'b0; m_load = 1'b0;
    last_strobe = 0; gap = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (gap > 0) begin
        rv = 1'b0;
        gap--;
      end else begin
        rv = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 39) == 0) gap = $urandom_range(5, 14);
      end
      rb  = 8'($urandom);
      sd  = ($urandom_range(0, 4) == 0);
      td  = {16'($urandom), 32'($urandom)};
      rdy = ($urandom_range(0, 2) != 0);
      bus.rx_byte_valid = rv;
      bus.rx_byte       = rb;
      bus.send_data     = sd;
      bus.tx_data       = td;
      bus.tx_byte_ready = rdy;

      e_full = (msg_q.size() == D);
      e_tout = (rx_q.size() > 0) && !rv && (c - last_strobe == T);
      @(negedge clk);
      chk("rnd_tx_vld", 64'(bus.tx_byte_valid), 64'(tx_q.size() > 0));
      if (tx_q.size() > 0) chk("rnd_tx_byte", 64'(bus.tx_byte), 64'(tx_q[0]));
      chk("rnd_full", 64'(bus.tx_full), 64'(e_full));
      chk("rnd_ovf",  64'(bus.tx_overflow), 64'(sd && e_full));
      chk("rnd_ds",   64'(bus.data_sent), 64'(m_ds));
      chk("rnd_tout", 64'(bus.rx_timeout), 64'(e_tout));
      chk("rnd_pkt",  64'(bus.packet_received), 64'(m_pkt));
      check_fields("rnd", m_cmd, m_addr, m_data);

      // RX reference: collect bytes; six make a message; an expired gap discards the partial one.
      m_pkt = 1'b0;
      if (rv) begin
        rx_q.push_back(rb);
        last_strobe = c;
        if (rx_q.size() == 6) begin
          m = '0;
          for (int i = 0; i < 6; i++) m = {m[39:0], rx_q[i]};
          m_data = m[31:0];
          m_addr = m[39:32];
          m_cmd  = m[44:40];
          m_pkt  = 1'b1;
          rx_q.delete();
        end
      end else if (e_tout) begin
        rx_q.delete();
      end

      // TX reference: message queue feeding a byte queue, one empty cycle per message load.
      m_ds = 1'b0;
      if (sd && !e_full) msg_q.push_back(td);
      if (m_load) begin
        m = msg_q.pop_front();
        for (int i = 0; i < 6; i++) tx_q.push_back(m[47-8*i -: 8]);
        m_load = 1'b0;
      end else if (tx_q.size() > 0) begin
        if (rdy) begin
          void'(tx_q.pop_front());
          if (tx_q.size() == 0) begin
            m_ds   = 1'b1;
            m_load = (msg_q.size() > 0);
          end
        end
      end else begin
        m_load = (msg_q.size() > 0);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Hard stop if the run never reaches its summary
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    got_ds = 0;
    vecs[0] = '{msg: 48'h0123456789AB, cmd: 5'h01, addr: 8'h23, data: 32'h456789AB};
    vecs[1] = '{msg: 48'hFF0012345678, cmd: 5'h1F, addr: 8'h00, data: 32'h12345678};
    vecs[2] = '{msg: 48'hE75ADEADBEEF, cmd: 5'h07, addr: 8'h5A, data: 32'hDEADBEEF};
    vecs[3] = '{msg: 48'h20C300000001, cmd: 5'h00, addr: 8'hC3, data: 32'h00000001};
    for (int i = 0; i < 6; i++) tx_msgs[i] = 48'h102030405060 + 48'(i) * 48'h010101010101;

    // Reset state
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // RX decode table
    for (int v = 0; v < 4; v++) begin
      send_rx_msg(vecs[v].msg);
      @(negedge clk);
      chk("vec_pkt", 64'(bus.packet_received), 1);
      check_fields("vec", vecs[v].cmd, vecs[v].addr, vecs[v].data);
      next_cycle();
      @(negedge clk);
      chk("vec_pkt_pulse_end", 64'(bus.packet_received), 0);
      next_cycle();
    end

    // Timeout discards 3 partial bytes exactly T cycles after the last one
    for (int b = 0; b < 3; b++) begin
      bus.rx_byte_valid = 1'b1;
      bus.rx_byte       = 8'h55 + 8'(b);
      next_cycle();
    end
    bus.rx_byte_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("tout_pulse", 64'(bus.rx_timeout), 64'(k == T));
      chk("tout_no_pkt", 64'(bus.packet_received), 0);
      next_cycle();
    end
    check_fields("tout_hold", vecs[3].cmd, vecs[3].addr, vecs[3].data);
    send_rx_msg(48'h1F2E3D4C5B6A);
    @(negedge clk);
    chk("tout_fresh_pkt", 64'(bus.packet_received), 1);
    check_fields("tout_fresh", 5'h1F, 8'h2E, 32'h3D4C5B6A);
    next_cycle();

    // Strobe landing on the expiry cycle keeps the partial message
    bus.rx_byte_valid = 1'b1; bus.rx_byte = 8'h0A; next_cycle();
    bus.rx_byte = 8'h0B; next_cycle();
    bus.rx_byte_valid = 1'b0;
    for (int k = 1; k < T; k++) begin
      @(negedge clk);
      chk("cancel_idle_no_tout", 64'(bus.rx_timeout), 0);
      next_cycle();
    end
    bus.rx_byte_valid = 1'b1; bus.rx_byte = 8'h0C;
    @(negedge clk);
    chk("cancel_edge_no_tout", 64'(bus.rx_timeout), 0);
    next_cycle();
    bus.rx_byte = 8'h0D; next_cycle();
    bus.rx_byte = 8'h0E; next_cycle();
    bus.rx_byte = 8'h0F; next_cycle();
    bus.rx_byte_valid = 1'b0;
    @(negedge clk);
    chk("cancel_pkt", 64'(bus.packet_received), 1);
    check_fields("cancel", 5'h0A, 8'h0B, 32'h0C0D0E0F);
    next_cycle();

    // TX serialise with ready high
    bus.tx_byte_ready = 1'b1;
    bus.send_data     = 1'b1;
    bus.tx_data       = 48'hA1B2C3D4E5F6;
    @(negedge clk);
    chk("ser_vld_n0", 64'(bus.tx_byte_valid), 0);
    next_cycle();
    bus.send_data = 1'b0;
    @(negedge clk);
    chk("ser_vld_n1", 64'(bus.tx_byte_valid), 0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ser_vld", 64'(bus.tx_byte_valid), 1);
      chk("ser_byte", 64'(bus.tx_byte), 64'(8'hA1 + 8'(i) * 8'h11));
      chk("ser_no_ds", 64'(bus.data_sent), 0);
      next_cycle();
    end
    @(negedge clk);
    chk("ser_ds", 64'(bus.data_sent), 1);
    chk("ser_vld_done", 64'(bus.tx_byte_valid), 0);
    next_cycle();
    @(negedge clk);
    chk("ser_ds_pulse_end", 64'(bus.data_sent), 0);
    next_cycle();

    // Backpressure: first message moves into the serialiser, so the queue fills on the 5th and drops the 6th
    bus.tx_byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.send_data = 1'b1;
      bus.tx_data   = tx_msgs[i];
      @(negedge clk);
      chk("bp_full", 64'(bus.tx_full), 64'(i == 5));
      chk("bp_ovf",  64'(bus.tx_overflow), 64'(i == 5));
      if (i >= 2) begin
        chk("bp_hold_vld",  64'(bus.tx_byte_valid), 1);
        chk("bp_hold_byte", 64'(bus.tx_byte), 64'(8'h10));
      end
      next_cycle();
    end
    bus.send_data     = 1'b0;
    bus.tx_byte_ready = 1'b1;
    got_q.delete();
    got_ds = 0;
    collect_tx(60);
    chk("bp_byte_count", 64'(got_q.size()), 30);
    chk("bp_ds_count", 64'(got_ds), 5);
    for (int i = 0; i < 30 && i < got_q.size(); i++)
      chk("bp_order", 64'(got_q[i]), 64'(tx_msgs[i/6][47-8*(i%6) -: 8]));
    @(negedge clk);
    chk("bp_drained_full", 64'(bus.tx_full), 0);
    chk("bp_drained_vld", 64'(bus.tx_byte_valid), 0);
    next_cycle();

    // Reset during TX byte 3 with 2 RX bytes pending
    bus.tx_byte_ready = 1'b1;
    bus.send_data = 1'b1; bus.tx_data = 48'hC0C1C2C3C4C5;
    bus.rx_byte_valid = 1'b1; bus.rx_byte = 8'h77;
    next_cycle();
    bus.tx_data = 48'hD0D1D2D3D4D5; bus.rx_byte = 8'h88;
    next_cycle();
    bus.send_data = 1'b0; bus.rx_byte_valid = 1'b0;
    next_cycle();
    next_cycle();
    chk("rst_pre_vld", 64'(bus.tx_byte_valid), 1);
    chk("rst_pre_byte", 64'(bus.tx_byte), 64'(8'hC2));
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    next_cycle();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_vld",  64'(bus.tx_byte_valid), 0);
      chk("post_rst_full", 64'(bus.tx_full), 0);
      chk("post_rst_tout", 64'(bus.rx_timeout), 0);
      chk("post_rst_ds",   64'(bus.data_sent), 0);
      next_cycle();
    end
    send_rx_msg(48'h9C4201020304);
    @(negedge clk);
    chk("post_rst_pkt", 64'(bus.packet_received), 1);
    check_fields("post_rst", 5'h1C, 8'h42, 32'h01020304);
    next_cycle();

    // Randomized traffic on both paths against the queue model
    run_random(3000, 5'h1C, 8'h42, 32'h01020304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
